pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the in-order integer pipeline. It keeps a shadow pipeline of destination and valid information for the execute stage (stage 0) and the NPOST post-execute stages. It generates fetch/decode hold, execute bubble and decode flush controls, plus per-operand forwarding selects for the execute stage. It supersedes the fixed two-source forward unit and the decode-stage load-use detector, and supports deeper memory pipelines with multi-cycle load latency and a global external freeze.

---
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order integer pipeline.
// It keeps a shadow copy of dst/valid for execute (stage 0) and NPOST later stages.
module pipe_hazard_ctrl #(
    parameter int REG_W    = 3,
    parameter int NPOST    = 2,
    parameter int LD_AVAIL = 2,
    localparam int FWD_W   = $clog2(NPOST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic             d_wr,
    input  logic             d_ld,
    input  logic [REG_W-1:0] d_dst,
    input  logic [REG_W-1:0] d_src1,
    input  logic [REG_W-1:0] d_src2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic             jump,
    input  logic             ext_stall,
    output logic             keep_f,
    output logic             keep_d,
    output logic             flush_d,
    output logic             bubble_e,
    output logic             keep_all,
    output logic [FWD_W-1:0] fwd1,
    output logic [FWD_W-1:0] fwd2,
    output logic             e_valid
);

    logic [NPOST:0]   vld_q, vld_d;
    logic [NPOST:0]   wr_q, wr_d;
    logic [NPOST:0]   ld_q, ld_d;
    logic [REG_W-1:0] dst_q [NPOST+1];
    logic [REG_W-1:0] dst_d [NPOST+1];
    logic [REG_W-1:0] src1_q, src1_d;
    logic [REG_W-1:0] src2_q, src2_d;
    logic             use1_q, use1_d;
    logic             use2_q, use2_d;
    logic             stall_ld;

    // A load is a hazard while it sits in a stage whose data is not yet forwardable.
    always_comb begin
        stall_ld = 1'b0;
        for (int k = 0; k <= NPOST; k++) begin
            if ((k + 1 < LD_AVAIL) && d_valid && vld_q[k] && wr_q[k] && ld_q[k] &&
                ((d_use1 && (dst_q[k] == d_src1)) || (d_use2 && (dst_q[k] == d_src2)))) begin
                stall_ld = 1'b1;
            end
        end
    end

    always_comb begin
        keep_f   = 1'b0;
        keep_d   = 1'b0;
        flush_d  = 1'b0;
        bubble_e = 1'b0;
        keep_all = ext_stall;
        if (!ext_stall) begin
            if (jump) begin
                flush_d  = 1'b1;
                bubble_e = 1'b1;
            end else if (stall_ld) begin
                keep_f   = 1'b1;
                keep_d   = 1'b1;
                bubble_e = 1'b1;
            end
        end
    end

    // Scan oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        for (int k = NPOST; k >= 1; k--) begin
            if (vld_q[0] && vld_q[k] && wr_q[k] && !(ld_q[k] && (k < LD_AVAIL))) begin
                if (use1_q && (dst_q[k] == src1_q)) fwd1 = FWD_W'(k);
                if (use2_q && (dst_q[k] == src2_q)) fwd2 = FWD_W'(k);
            end
        end
    end

    assign e_valid = vld_q[0];

    always_comb begin
        vld_d  = vld_q;
        wr_d   = wr_q;
        ld_d   = ld_q;
        dst_d  = dst_q;
        src1_d = src1_q;
        src2_d = src2_q;
        use1_d = use1_q;
        use2_d = use2_q;
        if (!ext_stall) begin
            for (int k = 1; k <= NPOST; k++) begin
                vld_d[k] = vld_q[k-1];
                wr_d[k]  = wr_q[k-1];
                ld_d[k]  = ld_q[k-1];
                dst_d[k] = dst_q[k-1];
            end
            vld_d[0] = d_valid & ~stall_ld & ~jump;
            wr_d[0]  = d_wr;
            ld_d[0]  = d_ld;
            dst_d[0] = d_dst;
            src1_d   = d_src1;
            src2_d   = d_src2;
            use1_d   = d_use1;
            use2_d   = d_use2;
        end
    end

    // Only valid bits need reset; every other field is qualified by its valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
        wr_q   <= wr_d;
        ld_q   <= ld_d;
        dst_q  <= dst_d;
        src1_q <= src1_d;
        src2_q <= src2_d;
        use1_q <= use1_d;
        use2_q <= use2_d;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations share stimulus and are each
// checked every cycle against an instruction-level model, plus literal scenarios.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_valid, d_wr, d_ld, d_use1, d_use2, jump, ext_stall;
    logic [2:0] d_dst, d_src1, d_src2;

    logic       a_kf, a_kd, a_fl, a_be, a_ka, a_ev;
    logic [1:0] a_fwd1, a_fwd2;
    logic       b_kf, b_kd, b_fl, b_be, b_ka, b_ev;
    logic [1:0] b_fwd1, b_fwd2;
    logic [11:0] a_vec, b_vec;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(3), .NPOST(2), .LD_AVAIL(2)) u_a (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_wr(d_wr), .d_ld(d_ld),
        .d_dst(d_dst), .d_src1(d_src1), .d_src2(d_src2), .d_use1(d_use1), .d_use2(d_use2),
        .jump(jump), .ext_stall(ext_stall), .keep_f(a_kf), .keep_d(a_kd), .flush_d(a_fl),
        .bubble_e(a_be), .keep_all(a_ka), .fwd1(a_fwd1), .fwd2(a_fwd2), .e_valid(a_ev)
    );

    pipe_hazard_ctrl #(.REG_W(3), .NPOST(3), .LD_AVAIL(3)) u_b (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_wr(d_wr), .d_ld(d_ld),
        .d_dst(d_dst), .d_src1(d_src1), .d_src2(d_src2), .d_use1(d_use1), .d_use2(d_use2),
        .jump(jump), .ext_stall(ext_stall), .keep_f(b_kf), .keep_d(b_kd), .flush_d(b_fl),
        .bubble_e(b_be), .keep_all(b_ka), .fwd1(b_fwd1), .fwd2(b_fwd2), .e_valid(b_ev)
    );

    assign a_vec = {a_kf, a_kd, a_fl, a_be, a_ka, a_ev, 1'b0, a_fwd1, 1'b0, a_fwd2};
    assign b_vec = {b_kf, b_kd, b_fl, b_be, b_ka, b_ev, 1'b0, b_fwd1, 1'b0, b_fwd2};

    // Model: each configuration is a list of in-flight instructions indexed by stage.
    typedef struct {
        bit v; bit wr; bit ld; int dst; int s1; int s2; bit u1; bit u2;
    } ent_t;
    ent_t mdl [2][7];

    function automatic int np(int c);
        return (c == 0) ? 2 : 3;
    endfunction

    function automatic int lda(int c);
        return (c == 0) ? 2 : 3;
    endfunction

    function automatic bit reads(int r);
        return (d_use1 && (int'(d_src1) == r)) || (d_use2 && (int'(d_src2) == r));
    endfunction

    // Decode must wait while a load whose data is not yet available targets one of its sources.
    function automatic bit mstall(int c);
        if (!d_valid) return 1'b0;
        for (int k = 0; k <= lda(c) - 2; k++) begin
            if (mdl[c][k].v && mdl[c][k].wr && mdl[c][k].ld && reads(mdl[c][k].dst)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int producer(int c, int r);
        for (int k = 1; k <= np(c); k++) begin
            if (mdl[c][k].v && mdl[c][k].wr && mdl[c][k].dst == r &&
                !(mdl[c][k].ld && k < lda(c))) return k;
        end
        return 0;
    endfunction

    function automatic logic [11:0] mout(int c);
        bit kf, kd, fl, be;
        int f1, f2;
        kf = 0; kd = 0; fl = 0; be = 0; f1 = 0; f2 = 0;
        if (!ext_stall) begin
            if (jump) begin
                fl = 1; be = 1;
            end else if (mstall(c)) begin
                kf = 1; kd = 1; be = 1;
            end
        end
        if (mdl[c][0].v) begin
            if (mdl[c][0].u1) f1 = producer(c, mdl[c][0].s1);
            if (mdl[c][0].u2) f2 = producer(c, mdl[c][0].s2);
        end
        return {kf, kd, fl, be, ext_stall, mdl[c][0].v, f1[2:0], f2[2:0]};
    endfunction

    task automatic mstep(int c);
        bit acc;
        if (!rst) begin
            for (int k = 0; k < 7; k++) mdl[c][k].v = 1'b0;
        end else if (!ext_stall) begin
            acc = d_valid && !mstall(c) && !jump;
            for (int k = np(c); k >= 1; k--) mdl[c][k] = mdl[c][k-1];
            mdl[c][0].v   = acc;
            mdl[c][0].wr  = d_wr;
            mdl[c][0].ld  = d_ld;
            mdl[c][0].dst = int'(d_dst);
            mdl[c][0].s1  = int'(d_src1);
            mdl[c][0].s2  = int'(d_src2);
            mdl[c][0].u1  = d_use1;
            mdl[c][0].u2  = d_use2;
        end
    endtask

    always @(posedge clk) begin
        mstep(0);
        mstep(1);
    end

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_cfgA", int'(a_vec), int'(mout(0)));
            chk("model_cfgB", int'(b_vec), int'(mout(1)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid = 0; d_wr = 0; d_ld = 0; d_dst = 0; d_src1 = 0; d_src2 = 0;
        d_use1 = 0; d_use2 = 0; jump = 0; ext_stall = 0;
    endtask

    task automatic dec(bit v, bit w, bit l, int dst, int s1, bit u1, int s2, bit u2);
        d_valid = v; d_wr = w; d_ld = l; d_dst = 3'(dst);
        d_src1 = 3'(s1); d_use1 = u1; d_src2 = 3'(s2); d_use2 = u2;
    endtask

    task automatic flush();
        idle();
        repeat (5) tick();
    endtask

    initial begin
        rst = 0;
        idle();
        tick();
        tick();
        rst = 1;
        chk_en = 1;
        @(negedge clk);
        chk("reset_outs_A", int'(a_vec), 0);
        chk("reset_outs_B", int'(b_vec), 0);

        // ADD r1 then SUB r5 = r1 - r6
        tick();
        dec(1, 1, 0, 1, 0, 0, 0, 0);
        tick();
        dec(1, 1, 0, 5, 1, 1, 6, 1);
        @(negedge clk);
        chk("alu_nostall_keep_f", a_kf, 0);
        tick();
        idle();
        @(negedge clk);
        chk("alu_fwd1", a_fwd1, 1);
        chk("alu_fwd2", a_fwd2, 0);
        chk("alu_e_valid", a_ev, 1);

        // LD r2 then ADD r7 = r3 + r2
        flush();
        dec(1, 1, 1, 2, 0, 0, 0, 0);
        tick();
        dec(1, 1, 0, 7, 3, 1, 2, 1);
        @(negedge clk);
        chk("ld_use_keep_f", a_kf, 1);
        chk("ld_use_keep_d", a_kd, 1);
        chk("ld_use_bubble_e", a_be, 1);
        tick();
        @(negedge clk);
        chk("ld_use_end_keep_f", a_kf, 0);
        tick();
        @(negedge clk);
        chk("ld_use_fwd2", a_fwd2, 2);
        chk("ld_use_fwd1", a_fwd1, 0);
        chk("ld_use_e_valid", a_ev, 1);

        // Deep config: LD r4 then use r4
        flush();
        dec(1, 1, 1, 4, 0, 0, 0, 0);
        tick();
        dec(1, 1, 0, 6, 4, 1, 0, 0);
        @(negedge clk);
        chk("deep_stall1", b_kf, 1);
        tick();
        @(negedge clk);
        chk("deep_stall2", b_kf, 1);
        chk("deep_stall2_bubble", b_be, 1);
        tick();
        @(negedge clk);
        chk("deep_stall_done", b_kf, 0);
        tick();
        idle();
        @(negedge clk);
        chk("deep_fwd1", b_fwd1, 3);
        chk("deep_e_valid", b_ev, 1);

        // ADD r3, SUB r3, OR reads r3: youngest wins
        flush();
        dec(1, 1, 0, 3, 0, 0, 0, 0);
        tick();
        dec(1, 1, 0, 3, 1, 1, 2, 1);
        tick();
        dec(1, 1, 0, 5, 3, 1, 2, 1);
        tick();
        idle();
        @(negedge clk);
        chk("youngest_fwd1", a_fwd1, 1);
        chk("youngest_fwd2", a_fwd2, 0);

        // Load-use hazard coincident with jump
        flush();
        dec(1, 1, 1, 2, 0, 0, 0, 0);
        tick();
        dec(1, 1, 0, 7, 2, 1, 0, 0);
        jump = 1;
        @(negedge clk);
        chk("jump_flush_d", a_fl, 1);
        chk("jump_bubble_e", a_be, 1);
        chk("jump_keep_f", a_kf, 0);
        chk("jump_keep_d", a_kd, 0);
        tick();
        idle();
        @(negedge clk);
        chk("jump_next_e_valid", a_ev, 0);

        // ext_stall held 3 cycles during a load-use stall
        flush();
        dec(1, 1, 1, 2, 0, 0, 0, 0);
        tick();
        dec(1, 1, 0, 7, 2, 1, 0, 0);
        ext_stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_keep_all", a_ka, 1);
            chk("frz_others", int'({a_kf, a_kd, a_fl, a_be}), 0);
            chk("frz_e_valid", a_ev, 1);
            tick();
        end
        ext_stall = 0;
        @(negedge clk);
        chk("frz_resume_keep_f", a_kf, 1);
        chk("frz_resume_bubble", a_be, 1);
        tick();
        @(negedge clk);
        chk("frz_done_keep_f", a_kf, 0);
        chk("frz_done_e_valid", a_ev, 0);
        tick();
        @(negedge clk);
        chk("frz_cons_fwd1", a_fwd1, 2);
        chk("frz_cons_e_valid", a_ev, 1);

        // Reset in the middle of a load-use stall
        flush();
        dec(1, 1, 1, 2, 0, 0, 0, 0);
        tick();
        dec(1, 1, 0, 7, 2, 1, 0, 0);
        @(negedge clk);
        chk("rst_pre_keep_f", a_kf, 1);
        rst = 0;
        tick();
        rst = 1;
        @(negedge clk);
        chk("rst_mid_A", int'(a_vec), 0);
        chk("rst_mid_B", int'(b_vec), 0);

        // Randomised traffic on a small register space for frequent hazards
        for (int i = 0; i < 3000; i++) begin
            tick();
            d_valid   = ($urandom_range(0, 3) != 0);
            d_wr      = ($urandom_range(0, 3) != 0);
            d_ld      = ($urandom_range(0, 2) == 0);
            d_dst     = 3'($urandom);
            d_src1    = 3'($urandom);
            d_src2    = 3'($urandom);
            d_use1    = ($urandom_range(0, 3) != 0);
            d_use2    = ($urandom_range(0, 1) != 0);
            jump      = ($urandom_range(0, 9) == 0);
            ext_stall = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 99) != 0);
        end
        tick();
        idle();
        rst = 1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
